// File: rtl/machine_timer_if.sv
// Bus port bundle for the machine timer register block.
`timescale 1ns/1ps
interface machine_timer_if;
  logic [2:1]  phase;
  logic        chip_select;
  logic        write_enable;
  logic [4:2]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output phase, chip_select, write_enable,
    output address, write_data,
    input  read_data
  );

  modport slave (
    input  phase, chip_select, write_enable,
    input  address, write_data,
    output read_data
  );
endinterface

// File: rtl/machine_timer.sv
// Machine timer: 64-bit mtime with prescaler, mtimecmp, msip,
// and the time/timeh CSR path with a coherent high-half snapshot.
`timescale 1ns/1ps
module machine_timer #(
  parameter int unsigned TICK_DIVIDER = 1
) (
  input  logic        clock,
  input  logic        reset,
  machine_timer_if.slave bus,
  input  logic        load_time,
  input  logic        load_time_h,
  output logic [31:0] time_out,
  output logic        pad_timer_interrupt,
  output logic        pad_software_interrupt
);

  localparam int TW =
    (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_DIVIDER - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          mtip_q, mtip_d;
  logic          msi_q, msi_d;

  logic wr;
  logic tick;

  assign wr = bus.chip_select && bus.write_enable
           && (bus.phase == 2'b10);
  assign tick = (tick_q == TICK_LAST);

  always_comb begin
    tick_d     = tick ? '0 : tick_q + TW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    // A write to either mtime half drops this edge's tick entirely
    unique case (1'b1)
      wr && (bus.address == 3'd0): begin
        msip_d = bus.write_data[0];
      end
      wr && (bus.address == 3'd2): begin
        mtimecmp_d[31:0] = bus.write_data;
      end
      wr && (bus.address == 3'd3): begin
        mtimecmp_d[63:32] = bus.write_data;
      end
      wr && (bus.address == 3'd4): begin
        mtime_d = {mtime_q[63:32], bus.write_data};
        tick_d  = '0;
      end
      wr && (bus.address == 3'd5): begin
        mtime_d = {bus.write_data, mtime_q[31:0]};
        tick_d  = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    shadow_d = load_time ? mtime_q[63:32] : shadow_q;
    mtip_d   = (mtime_q >= mtimecmp_q);
    msi_d    = msip_q;
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.chip_select) begin
      unique case (bus.address)
        3'd0:    bus.read_data = {31'b0, msip_q};
        3'd2:    bus.read_data = mtimecmp_q[31:0];
        3'd3:    bus.read_data = mtimecmp_q[63:32];
        3'd4:    bus.read_data = mtime_q[31:0];
        3'd5:    bus.read_data = mtime_q[63:32];
        default: bus.read_data = '0;
      endcase
    end
  end

  always_comb begin
    time_out = '0;
    if (load_time) begin
      time_out = mtime_q[31:0];
    end else if (load_time_h) begin
      time_out = shadow_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q     <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      shadow_q   <= '0;
      mtip_q     <= 1'b0;
      msi_q      <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      shadow_q   <= shadow_d;
      mtip_q     <= mtip_d;
      msi_q      <= msi_d;
    end
  end

  assign pad_timer_interrupt    = mtip_q;
  assign pad_software_interrupt = msi_q;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer with divider 4 and divider 1.
`timescale 1ns/1ps
module tb_machine_timer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  machine_timer_if b4 ();
  machine_timer_if b1 ();

  logic        lt4 = 0, lth4 = 0, lt1 = 0, lth1 = 0;
  logic [31:0] to4, to1;
  logic        mtip4, msi4, mtip1, msi1;

  int total = 0;
  int bad = 0;

  machine_timer #(.TICK_DIVIDER(4)) dut4 (
    .clock(clock), .reset(reset), .bus(b4),
    .load_time(lt4), .load_time_h(lth4), .time_out(to4),
    .pad_timer_interrupt(mtip4),
    .pad_software_interrupt(msi4)
  );

  machine_timer #(.TICK_DIVIDER(1)) dut1 (
    .clock(clock), .reset(reset), .bus(b1),
    .load_time(lt1), .load_time_h(lth1), .time_out(to1),
    .pad_timer_interrupt(mtip1),
    .pad_software_interrupt(msi1)
  );

  task automatic idle();
    b4.chip_select = 0; b4.write_enable = 0;
    b4.phase = 2'b01; b4.address = 3'd0; b4.write_data = 0;
    b1.chip_select = 0; b1.write_enable = 0;
    b1.phase = 2'b01; b1.address = 3'd0; b1.write_data = 0;
  endtask

  task automatic wr(input int d, input logic [2:0] a,
                    input logic [31:0] v, input logic [1:0] ph);
    @(negedge clock);
    if (d == 4) begin
      b4.chip_select = 1; b4.write_enable = 1;
      b4.address = a; b4.write_data = v; b4.phase = ph;
    end else begin
      b1.chip_select = 1; b1.write_enable = 1;
      b1.address = a; b1.write_data = v; b1.phase = ph;
    end
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic rd(input int d, input logic [2:0] a,
                    output logic [31:0] v);
    if (d == 4) begin
      b4.chip_select = 1; b4.write_enable = 0; b4.address = a;
      #1 v = b4.read_data;
      b4.chip_select = 0;
    end else begin
      b1.chip_select = 1; b1.write_enable = 0; b1.address = a;
      #1 v = b1.read_data;
      b1.chip_select = 0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_r [5];
    logic [2:0]  idx [5];
    idx = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    exp_r = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      rd(4, idx[i], v);
      total++;
      if (v !== exp_r[i]) begin
        bad++;
        $display("FAIL reset_idx%0d got=%h exp=%h",
                 idx[i], v, exp_r[i]);
      end
    end
    total++;
    if ({mtip4, msi4, mtip1, msi1} !== 4'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b exp=0000",
               {mtip4, msi4, mtip1, msi1});
    end
    b4.address = 3'd3;
    #1;
    total++;
    if (b4.read_data !== 32'h0) begin
      bad++;
      $display("FAIL rdata_no_cs got=%h exp=0", b4.read_data);
    end
    lth1 = 1;
    #1;
    total++;
    if (to1 !== 32'h0) begin
      bad++;
      $display("FAIL shadow_reset got=%h exp=0", to1);
    end
    lth1 = 0;
  endtask

  task automatic test_prescale_wrap();
    logic [31:0] v, e;
    wr(4, 3'd5, 32'hFFFF_FFFF, 2'b10);
    wr(4, 3'd4, 32'hFFFF_FFFE, 2'b10);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      rd(4, 3'd4, v);
      e = (k < 4) ? 32'hFFFF_FFFE :
          (k < 8) ? 32'hFFFF_FFFF : 32'h0;
      total++;
      if (v !== e) begin
        bad++;
        $display("FAIL prescale_lo_edge%0d got=%h exp=%h", k, v, e);
      end
    end
    rd(4, 3'd5, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL wrap_hi got=%h exp=0", v);
    end
    wr(4, 3'd4, 32'h0000_1234, 2'b01);
    rd(4, 3'd4, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL phase01_write got=%h exp=0", v);
    end
  endtask

  task automatic test_timer_irq();
    logic [31:0] v;
    wr(1, 3'd5, 32'h0, 2'b10);
    wr(1, 3'd4, 32'h10, 2'b10);
    wr(1, 3'd3, 32'h0, 2'b10);
    wr(1, 3'd2, 32'h20, 2'b10);
    rd(1, 3'd4, v);
    total++;
    if (v !== 32'h12) begin
      bad++;
      $display("FAIL mtime_after_setup got=%h exp=12", v);
    end
    repeat (14) @(posedge clock);
    #1;
    rd(1, 3'd4, v);
    total++;
    if (v !== 32'h20 || mtip1 !== 1'b0) begin
      bad++;
      $display("FAIL mtip_at_equal got=%h/%b exp=20/0", v, mtip1);
    end
    @(posedge clock);
    #1;
    total++;
    if (mtip1 !== 1'b1) begin
      bad++;
      $display("FAIL mtip_rise got=%b exp=1", mtip1);
    end
    wr(1, 3'd2, 32'h1000, 2'b10);
    @(posedge clock);
    #1;
    total++;
    if (mtip1 !== 1'b0) begin
      bad++;
      $display("FAIL mtip_clear got=%b exp=0", mtip1);
    end
  endtask

  task automatic test_software_irq();
    logic [31:0] v;
    wr(1, 3'd0, 32'hFFFF_FFFF, 2'b10);
    rd(1, 3'd0, v);
    total++;
    if (v !== 32'h1 || msi1 !== 1'b0) begin
      bad++;
      $display("FAIL msip_write got=%h/%b exp=1/0", v, msi1);
    end
    @(posedge clock);
    #1;
    total++;
    if (msi1 !== 1'b1) begin
      bad++;
      $display("FAIL msi_rise got=%b exp=1", msi1);
    end
    wr(1, 3'd0, 32'h0, 2'b10);
    @(posedge clock);
    #1;
    total++;
    if (msi1 !== 1'b0) begin
      bad++;
      $display("FAIL msi_clear got=%b exp=0", msi1);
    end
  endtask

  task automatic test_coherent_time();
    logic [31:0] v;
    wr(1, 3'd5, 32'h1, 2'b10);
    wr(1, 3'd4, 32'hFFFF_FFFF, 2'b10);
    @(negedge clock);
    lt1 = 1;
    lth1 = 1;
    #1;
    total++;
    if (to1 !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL time_lo got=%h exp=ffffffff", to1);
    end
    @(posedge clock);
    #1;
    lt1 = 0;
    #1;
    total++;
    if (to1 !== 32'h1) begin
      bad++;
      $display("FAIL timeh_coherent got=%h exp=00000001", to1);
    end
    rd(1, 3'd5, v);
    total++;
    if (v !== 32'h2) begin
      bad++;
      $display("FAIL carry_hi got=%h exp=2", v);
    end
    lth1 = 0;
    #1;
    total++;
    if (to1 !== 32'h0) begin
      bad++;
      $display("FAIL time_idle got=%h exp=0", to1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(1, 3'd4, 32'h5, 2'b10);
    rd(1, 3'd4, v);
    total++;
    if (v !== 32'h5) begin
      bad++;
      $display("FAIL write_tick_div1 got=%h exp=5", v);
    end
    wr(4, 3'd4, 32'h100, 2'b10);
    repeat (3) @(posedge clock);
    wr(4, 3'd4, 32'h5, 2'b10);
    rd(4, 3'd4, v);
    total++;
    if (v !== 32'h5) begin
      bad++;
      $display("FAIL write_tick_div4 got=%h exp=5", v);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    rd(4, 3'd4, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_count got=%h exp=0", v);
    end
    @(negedge clock);
    reset = 0;
    repeat (3) @(posedge clock);
    #1;
    rd(4, 3'd4, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL no_early_tick got=%h exp=0", v);
    end
    @(posedge clock);
    #1;
    rd(4, 3'd4, v);
    total++;
    if (v !== 32'h1) begin
      bad++;
      $display("FAIL first_tick got=%h exp=1", v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_prescale_wrap();
    test_timer_irq();
    test_software_irq();
    test_coherent_time();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
